// File: rtl/green_led_pkg.sv
// rtl/green_led_pkg.sv - shared constants and channel-state encoding for the green LED fader
package green_led_pkg;

    localparam int LEVEL_W   = 4;
    localparam int PWM_STEPS = 16;
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = 4'd15;

    typedef enum logic [1:0] {
        CH_OFF    = 2'd0,
        CH_ON     = 2'd1,
        CH_FADING = 2'd2
    } ch_state_e;

endpackage

// File: rtl/green_led_fader_if.sv
// rtl/green_led_fader_if.sv - pattern/enable inputs and PWM drive outputs of the fader
interface green_led_fader_if #(
    parameter int WIDTH = 9
);
    logic [WIDTH-1:0] led_in;
    logic             enable;
    logic [WIDTH-1:0] led_out;
    logic             period_strobe;

    modport master (
        output led_in,
        output enable,
        input  led_out,
        input  period_strobe
    );

    modport slave (
        input  led_in,
        input  enable,
        output led_out,
        output period_strobe
    );
endinterface

// File: rtl/led_fade_channel.sv
// rtl/led_fade_channel.sv - one LED channel: on/fade state machine, level and PWM compare
module led_fade_channel
    import green_led_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               boundary,
    input  logic               fade_step,
    input  logic               req,
    input  logic               enable,
    input  logic [LEVEL_W-1:0] phase,
    output logic               led
);

    localparam logic [1:0] S_OFF    = CH_OFF;
    localparam logic [1:0] S_ON     = CH_ON;
    localparam logic [1:0] S_FADING = CH_FADING;

    logic [1:0]         state;
    logic [LEVEL_W-1:0] level;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_OFF;
            level <= '0;
            led   <= 1'b0;
        end else begin
            led <= enable && (level == LEVEL_MAX || phase < level);
            if (!enable) begin
                state <= S_OFF;
                level <= '0;
            end else begin
                case (state)
                    S_OFF: begin
                        if (boundary && req) begin
                            state <= S_ON;
                            level <= LEVEL_MAX;
                        end
                    end
                    S_ON: begin
                        // Fading starts at full level; the first decrement waits for the next fade_step.
                        if (boundary && !req) begin
                            state <= S_FADING;
                            level <= LEVEL_MAX;
                        end
                    end
                    S_FADING: begin
                        if (boundary && req) begin
                            state <= S_ON;
                            level <= LEVEL_MAX;
                        end else if (fade_step) begin
                            level <= level - 1'b1;
                            if (level == 4'd1) begin
                                state <= S_OFF;
                            end
                        end
                    end
                    default: begin
                        state <= S_OFF;
                        level <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/green_led_fader.sv
// rtl/green_led_fader.sv - PWM fade driver for the green LED PIO pattern
module green_led_fader
    import green_led_pkg::*;
#(
    parameter int WIDTH        = 9,
    parameter int PRESCALE     = 3125,
    parameter int FADE_PERIODS = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    green_led_fader_if.slave  bus
);

    localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int FADE_W = (FADE_PERIODS > 1) ? $clog2(FADE_PERIODS) : 1;
    localparam logic [PRE_W-1:0]   PRE_LAST  = PRE_W'(PRESCALE - 1);
    localparam logic [FADE_W-1:0]  FADE_LAST = FADE_W'(FADE_PERIODS - 1);
    localparam logic [LEVEL_W-1:0] PHASE_LAST = LEVEL_W'(PWM_STEPS - 1);

    logic [PRE_W-1:0]   pre_cnt;
    logic [LEVEL_W-1:0] phase;
    logic [FADE_W-1:0]  fade_cnt;
    logic [WIDTH-1:0]   seen;
    logic [WIDTH-1:0]   req;
    logic [WIDTH-1:0]   led_q;
    logic               tick;
    logic               boundary;
    logic               fade_step;
    logic               strobe_q;

    assign tick      = (pre_cnt == PRE_LAST);
    assign boundary  = tick && (phase == PHASE_LAST);
    assign fade_step = boundary && (fade_cnt == FADE_LAST);
    assign req       = seen | bus.led_in;

    // Timebase keeps running regardless of enable so re-enabled channels stay period-aligned.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt  <= '0;
            phase    <= '0;
            fade_cnt <= '0;
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= boundary;
            if (tick) begin
                pre_cnt <= '0;
                phase   <= phase + 1'b1;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end
            if (boundary) begin
                fade_cnt <= (fade_cnt == FADE_LAST) ? '0 : fade_cnt + 1'b1;
            end
        end
    end

    // Sticky capture of any high cycle within the current period, restarted at each boundary.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seen <= '0;
        end else if (!bus.enable) begin
            seen <= '0;
        end else if (boundary) begin
            seen <= bus.led_in;
        end else begin
            seen <= seen | bus.led_in;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        led_fade_channel u_chan (
            .clk       (clk),
            .reset_n   (reset_n),
            .boundary  (boundary),
            .fade_step (fade_step),
            .req       (req[i]),
            .enable    (bus.enable),
            .phase     (phase),
            .led       (led_q[i])
        );
    end

    assign bus.led_out       = led_q;
    assign bus.period_strobe = strobe_q;

endmodule
